// File: rtl/regfile_sb.sv
// Parametrised register file with two asynchronous read ports, a per-register busy scoreboard and a sequenced scoreboard flush.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a0,
    input  logic [ADDR_W-1:0] a1,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic              busy0,
    output logic              busy1,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    output logic              flushing,
    output logic              any_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH - 2);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] data_q [DEPTH];

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Exit is checked before the increment, so the counter never wraps.
                if (cnt_q == LAST_PAIR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(2);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (state_q == CLEAR) begin
            busy_d[cnt_q]               = 1'b0;
            busy_d[cnt_q | ADDR_W'(1)]  = 1'b0;
        end
        if (write_enable) begin
            busy_d[wr] = 1'b0;
        end
        // A new producer overrides the retiring one on the same register.
        if (rsv_en && (state_q == IDLE)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            if (write_enable && !is_zero(wr)) begin
                data_q[wr] <= din;
            end
        end
    end

    always_comb begin
        q0    = is_zero(a0) ? '0 : data_q[a0];
        q1    = is_zero(a1) ? '0 : data_q[a1];
        busy0 = busy_q[a0];
        busy1 = busy_q[a1];
`ifdef REGFILE_BYPASS_EN
        if (write_enable && (wr == a0) && !is_zero(a0)) begin
            q0 = din;
        end
        if (write_enable && (wr == a1) && !is_zero(a1)) begin
            q1 = din;
        end
        if (write_enable && (wr == a0) && !(rsv_en && (rsv_addr == a0))) begin
            busy0 = 1'b0;
        end
        if (write_enable && (wr == a1) && !(rsv_en && (rsv_addr == a1))) begin
            busy1 = 1'b0;
        end
`endif
    end

    assign any_busy = |busy_q;
    assign flushing = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset, read/write, scoreboard, flush sequencing, reset mid-flush and forwarding.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] q0, q1;
    logic              busy0, busy1;
    logic              write_enable;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] din;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              flush;
    logic              flushing;
    logic              any_busy;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .a0           (a0),
        .a1           (a1),
        .q0           (q0),
        .q1           (q1),
        .busy0        (busy0),
        .busy1        (busy1),
        .write_enable (write_enable),
        .wr           (wr),
        .din          (din),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .flush        (flush),
        .flushing     (flushing),
        .any_busy     (any_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] mdl_data [DEPTH];
    logic              mdl_busy [DEPTH];
    logic [2*DATA_W+1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mdl_data[i] = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    // driver: one clock cycle of stimulus, model follows the committed edge
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic rv, input logic [ADDR_W-1:0] ra, input logic fl);
        write_enable = we; wr = wa; din = wd;
        rsv_en = rv; rsv_addr = ra; flush = fl;
        @(posedge clk); #1;
        if (we && wa != 0) mdl_data[wa] = wd;
        if (we) mdl_busy[wa] = 1'b0;
        if (rv && ra != 0) mdl_busy[ra] = 1'b1;
        write_enable = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    // scoreboard probe: push expectation when addresses are driven, pop when outputs settle
    task automatic probe(input logic [ADDR_W-1:0] x0, input logic [ADDR_W-1:0] x1);
        logic [2*DATA_W+1:0] e;
        a0 = x0; a1 = x1;
        exp_q.push_back({mdl_busy[x0], mdl_busy[x1], mdl_data[x0], mdl_data[x1]});
        #1;
        e = exp_q.pop_front();
        check($sformatf("q0@%0d", x0), 64'(q0), 64'(e[2*DATA_W-1:DATA_W]));
        check($sformatf("q1@%0d", x1), 64'(q1), 64'(e[DATA_W-1:0]));
        check($sformatf("busy0@%0d", x0), 64'(busy0), 64'(e[2*DATA_W+1]));
        check($sformatf("busy1@%0d", x1), 64'(busy1), 64'(e[2*DATA_W]));
    endtask

    initial begin
        int n;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        rst = 1'b0; a0 = '0; a1 = '0;
        write_enable = 1'b0; wr = '0; din = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        probe(5'd5, 5'd31);
        check("rst_any_busy", 64'(any_busy), 64'd0);
        check("rst_flushing", 64'(flushing), 64'd0);

        // write / read, hardwired zero
        cycle(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        probe(5'd7, 5'd0);
        cycle(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0);
        probe(5'd7, 5'd0);

        // same-cycle write to the read address
        write_enable = 1'b1; wr = 5'd4; din = 32'hA5A5A5A5; a0 = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_q0", 64'(q0), 64'hA5A5A5A5);
`else
        check("nobypass_q0", 64'(q0), 64'h0);
`endif
        @(posedge clk); #1;
        mdl_data[4] = 32'hA5A5A5A5;
        write_enable = 1'b0;
        probe(5'd4, 5'd7);

        // scoreboard: reserve, retire, same-cycle collision, reserve of r0
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        probe(5'd3, 5'd4);
        check("rsv_any_busy", 64'(any_busy), 64'd1);
        cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0);
        probe(5'd3, 5'd4);
        check("retire_any_busy", 64'(any_busy), 64'd0);
        cycle(1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 1'b0);
        probe(5'd3, 5'd0);
        cycle(1'b1, 5'd3, 32'h55, 1'b1, 5'd6, 1'b0);
        probe(5'd3, 5'd6);
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 1'b0);
        probe(5'd6, 5'd0);
        check("r0_rsv_any_busy", 64'(any_busy), 64'd0);

        // random writes
        for (int i = 0; i < 8; i++) begin
            ra = 5'($urandom_range(1, DEPTH - 1));
            rd = $urandom;
            cycle(1'b1, ra, rd, 1'b0, 5'd0, 1'b0);
            probe(ra, 5'($urandom_range(0, DEPTH - 1)));
        end

        // flush sequence
        cycle(1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 5'd30, 32'h30303030, 1'b0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 1'b0);
        probe(5'd9, 5'd30);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        check("flush_start", 64'(flushing), 64'd1);
        n = 0;
        while (flushing && n < 40) begin
            n++;
            if (n == 10) begin
                // late reservation and re-flush must both be ignored
                rsv_en = 1'b1; rsv_addr = 5'd5; flush = 1'b1;
                write_enable = 1'b1; wr = 5'd20; din = 32'h20202020;
            end
            @(posedge clk); #1;
            rsv_en = 1'b0; flush = 1'b0; write_enable = 1'b0;
        end
        check("flush_len", 64'(n), 64'd16);
        mdl_data[20] = 32'h20202020;
        for (int i = 0; i < DEPTH; i++) mdl_busy[i] = 1'b0;
        check("flush_any_busy", 64'(any_busy), 64'd0);
        check("flush_done", 64'(flushing), 64'd0);
        probe(5'd1, 5'd9);
        probe(5'd30, 5'd20);
        probe(5'd5, 5'd4);

        // reset mid-flush
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        n = 1;
        while (flushing && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check("midflush_reach", 64'(n), 64'd5);
        check("midflush_active", 64'(flushing), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        check("midflush_flushing", 64'(flushing), 64'd0);
        check("midflush_any_busy", 64'(any_busy), 64'd0);
        for (int i = 0; i < DEPTH; i += 2) probe(5'(i), 5'(i + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 register file.
- Generic width/depth, synchronous write, two asynchronous read ports, optional hardwired-zero entry 0.
- Integrated per-register busy scoreboard: reservations set by issue, cleared by writeback, with a sequenced scoreboard flush.
- Sits between decode/issue and writeback in the RISC-V core pipeline.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_R0, 1, 1 = entry 0 reads 0, ignores writes and reservations; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- a0  in  ADDR_W  read address, port 0.
- a1  in  ADDR_W  read address, port 1.
- q0  out  DATA_W  read data, port 0 (combinational).
- q1  out  DATA_W  read data, port 1 (combinational).
- busy0  out  1  scoreboard bit of a0 (combinational).
- busy1  out  1  scoreboard bit of a1 (combinational).
- write_enable  in  1  writeback strobe.
- wr  in  ADDR_W  writeback address.
- din  in  DATA_W  writeback data.
- rsv_en  in  1  reserve (mark busy) request.
- rsv_addr  in  ADDR_W  register to reserve.
- flush  in  1  start scoreboard clear sequence.
- flushing  out  1  high while the clear sequence runs.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset (rst==0 at posedge):
  - All registers := 0; all busy bits := 0.
  - FSM := IDLE; flush counter := 0.
  - Next cycle: flushing=0, any_busy=0; q0/q1 = 0 for every address.
- Write: if write_enable, data[wr] := din at posedge.
  - ZERO_R0=1 and wr==0: write discarded.
- Read: q0 = data[a0], q1 = data[a1], combinational. ZERO_R0=1 forces address 0 to 0.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - write_enable clears busy[wr].
  - Same address, same cycle: rsv_en wins, busy stays 1 (new producer overrides retiring one).
  - Different addresses in the same cycle: both updates take effect.
  - ZERO_R0=1: busy[0] is constant 0.
- Flush FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on flush=1; counter := 0.
  - CLEAR clears busy[counter] and busy[counter+1] each cycle (two per cycle), counter += 2.
  - Leave CLEAR -> IDLE on the cycle that clears entries DEPTH-2 and DEPTH-1. CLEAR therefore lasts DEPTH/2 cycles.
  - flushing = (state==CLEAR), registered.
  - flush asserted while already in CLEAR: ignored, no restart.
  - During CLEAR: rsv_en requests are dropped; writes still update data; write_enable busy clears still apply.
  - Register data is never touched by the flush.
- any_busy is combinational OR of busy[]. It reads 0 in the cycle after CLEAR exits, given no new reservations.
- rst low mid-CLEAR: immediate return to IDLE, everything cleared as for reset.
- Counter width ADDR_W. Wrap is unreachable because the exit condition is checked first.

Optional Feature:
- REGFILE_BYPASS_EN, when defined:
  - If write_enable && wr==a0 (and not hardwired zero), q0 = din in the same cycle. Same for q1/a1.
  - busy0/busy1 read 0 when the same-cycle write targets that address and rsv_en does not target it.
  - This gives write-through forwarding so decode sees writeback results without a stall.
- When not defined: q/busy reflect stored state only; new values are visible the cycle after the write.

Test Plan:
- Reset then read:
  - Hold rst=0 two cycles, release.
  - Read a0=5, a1=31 -> q0=0, q1=0, busy0=busy1=0, any_busy=0, flushing=0.
- Write/read:
  - write_enable=1, wr=7, din=0xDEADBEEF.
  - Next cycle a0=7 -> q0=0xDEADBEEF.
  - With ZERO_R0=1: write wr=0, din=0x1234 -> a1=0 gives q1=0.
- Scoreboard:
  - rsv_en, rsv_addr=3 -> next cycle busy0=1 at a0=3, any_busy=1.
  - Write wr=3 -> busy0=0.
  - Same-cycle rsv_en and write to 3 -> busy0 stays 1.
- Flush (DEPTH=32):
  - Reserve regs 1, 9, 30, then pulse flush.
  - flushing=1 for exactly 16 cycles.
  - Afterwards any_busy=0 and data in regs 1/9/30 is unchanged.
  - rsv_en during CLEAR is dropped.
- Reset mid-flush: assert rst=0 at the 5th CLEAR cycle -> next cycle flushing=0, all registers read 0.
- Bypass (REGFILE_BYPASS_EN defined):
  - write wr=4, din=0xA5A5A5A5 with a0=4 in the same cycle -> q0=0xA5A5A5A5 in that cycle.
  - Undefined -> q0 shows the old value that cycle and the new value the next.
